// File: rtl/eth_pkg.sv
// Shared types and constants for the receive-side destination-address filter.
package eth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAPT,
    SCAN,
    WAITEND,
    VERDICT,
    LOAD
  } flt_state_e;

  localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;
  localparam logic [3:0]  NOHIT         = 4'hF;
  localparam int          WORDS_PER_MAC = 3;

endpackage

// File: rtl/eth_rx_addr_filter_if.sv
// Receive-buffer write stream snooped by the address filter.
// Signal suffixes follow the filter's point of view (it only ever listens).
interface eth_rx_addr_filter_if #(
  parameter int AW = 10
);
  logic          rxwrn_i;
  logic [AW-1:0] rxaddr_i;
  logic [15:0]   rxdata_i;
  logic          rxrdy_i;

  modport master (output rxwrn_i, rxaddr_i, rxdata_i, rxrdy_i);
  modport slave  (input  rxwrn_i, rxaddr_i, rxdata_i, rxrdy_i);
endinterface

// File: rtl/eth_addr_table.sv
// Station address table: NADDR x 48-bit entries, written one 16-bit word at a
// time, with per-entry valid bits and a combinational indexed read port.
module eth_addr_table
  import eth_pkg::*;
#(
  parameter int NADDR = 14
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [3:0]       wr_ent_i,
  input  logic [1:0]       wr_word_i,
  input  logic [15:0]      wr_data_i,
  input  logic [3:0]       rd_idx_i,
  output logic [47:0]      rd_mac_o,
  output logic             rd_vld_o,
  output logic [NADDR-1:0] vld_o
);

  localparam int MAC_W = 16 * WORDS_PER_MAC;

  logic [MAC_W-1:0] r_mac [NADDR];
  logic [NADDR-1:0] r_vld;

  // NOTE: table data has no reset; the valid bits alone decide whether an entry is used.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      case (wr_word_i)
        2'd0:    r_mac[wr_ent_i][15:0]  <= wr_data_i;
        2'd1:    r_mac[wr_ent_i][31:16] <= wr_data_i;
        default: r_mac[wr_ent_i][47:32] <= wr_data_i;
      endcase
    end
  end

  // An entry becomes usable once its last word lands.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld <= '0;
    end else if (we_i && wr_word_i == 2'd2) begin
      r_vld[wr_ent_i] <= 1'b1;
    end
  end

  // NOTE: defaults first so no path through the block can infer a latch.
  always_comb begin
    rd_mac_o = '0;
    rd_vld_o = 1'b0;
    if (int'(rd_idx_i) < NADDR) begin
      rd_mac_o = r_mac[rd_idx_i];
      rd_vld_o = r_vld[rd_idx_i];
    end
  end

  assign vld_o = r_vld;

endmodule

// File: rtl/eth_rx_addr_filter.sv
// Receive destination-address filter: snoops buffer writes, matches the
// destination MAC against the station table and strobes an accept/reject
// verdict at frame end. Define FLT_STATS_EN to add the rej_cnt_o counter.
module eth_rx_addr_filter
  import eth_pkg::*;
#(
  parameter int NADDR = 14,
  parameter int AW    = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  eth_rx_addr_filter_if.slave  bus,
  input  logic                 setup_i,
  input  logic                 mcast_i,
  input  logic                 promis_i,
  output logic                 vld_o,
  output logic                 accept_o,
  output logic [3:0]           hit_idx_o,
  output logic                 bcast_o,
  output logic                 runt_o,
  output logic                 setup_done_o,
  output logic [NADDR-1:0]     tbl_vld_o
`ifdef FLT_STATS_EN
  ,
  output logic [15:0]          rej_cnt_o
`endif
);

  localparam int         LOAD_WORDS = WORDS_PER_MAC * NADDR;
  localparam logic [3:0] LAST_IDX   = 4'(NADDR - 1);

  flt_state_e  r_state;
  logic [47:0] r_dst;
  logic [3:0]  r_idx;
  logic [3:0]  r_hit_idx;
  logic        r_rdy_q;
  logic        r_pend;
  logic        r_runt;

  logic        r_vld;
  logic        r_accept;
  logic        r_bcast;
  logic        r_runt_o;
  logic [3:0]  r_hit_idx_o;
  logic        r_setup_done;

  logic        w_wr;
  logic        w_start;
  logic        w_rdy_rise;
  logic        w_tbl_we;
  logic [3:0]  w_ld_ent;
  logic [1:0]  w_ld_word;
  logic [47:0] w_rd_mac;
  logic        w_rd_vld;
  logic        w_hit;
  logic        w_accept;

  assign w_wr       = ~bus.rxwrn_i;
  assign w_start    = w_wr && (bus.rxaddr_i == '0);
  assign w_rdy_rise = bus.rxrdy_i & ~r_rdy_q;

  // Setup-frame word a lands in entry a/3, word a%3.
  assign w_ld_ent  = 4'(bus.rxaddr_i / AW'(WORDS_PER_MAC));
  assign w_ld_word = 2'(bus.rxaddr_i % AW'(WORDS_PER_MAC));
  assign w_tbl_we  = w_wr && (w_start ? setup_i : (r_state == LOAD))
                     && (int'(bus.rxaddr_i) < LOAD_WORDS);

  eth_addr_table #(
    .NADDR (NADDR)
  ) u_table (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .we_i      (w_tbl_we),
    .wr_ent_i  (w_ld_ent),
    .wr_word_i (w_ld_word),
    .wr_data_i (bus.rxdata_i),
    .rd_idx_i  (r_idx),
    .rd_mac_o  (w_rd_mac),
    .rd_vld_o  (w_rd_vld),
    .vld_o     (tbl_vld_o)
  );

  assign w_hit    = w_rd_vld && (w_rd_mac == r_dst);
  assign w_accept = promis_i | (~r_runt & ((r_dst == BCAST_MAC) | (r_dst[0] & mcast_i)
                                           | (r_hit_idx != NOHIT)));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_dst        <= '0;
      r_idx        <= '0;
      r_hit_idx    <= NOHIT;
      r_rdy_q      <= 1'b0;
      r_pend       <= 1'b0;
      r_runt       <= 1'b0;
      r_vld        <= 1'b0;
      r_accept     <= 1'b0;
      r_bcast      <= 1'b0;
      r_runt_o     <= 1'b0;
      r_hit_idx_o  <= NOHIT;
      r_setup_done <= 1'b0;
    end else begin
      r_rdy_q      <= bus.rxrdy_i;
      r_vld        <= 1'b0;
      r_setup_done <= 1'b0;
      // A write to address 0 starts a new frame from any state; the old one is dropped.
      if (w_start) begin
        r_idx         <= '0;
        r_hit_idx     <= NOHIT;
        r_pend        <= 1'b0;
        r_runt        <= 1'b0;
        r_dst[15:0]   <= bus.rxdata_i;
        r_state       <= setup_i ? LOAD : CAPT;
      end else begin
        case (r_state)
          CAPT: begin
            if (w_wr && bus.rxaddr_i == AW'(1)) begin
              r_dst[31:16] <= bus.rxdata_i;
            end
            if (w_wr && bus.rxaddr_i == AW'(2)) begin
              r_dst[47:32] <= bus.rxdata_i;
              r_pend       <= w_rdy_rise;
              r_state      <= SCAN;
            end else if (w_rdy_rise) begin
              r_runt  <= 1'b1;
              r_state <= VERDICT;
            end
          end
          SCAN: begin
            if (w_hit || r_idx == LAST_IDX) begin
              if (w_hit) begin
                r_hit_idx <= r_idx;
              end
              r_state <= (r_pend || w_rdy_rise) ? VERDICT : WAITEND;
            end else begin
              r_idx <= r_idx + 4'd1;
              if (w_rdy_rise) begin
                r_pend <= 1'b1;
              end
            end
          end
          WAITEND: begin
            if (w_rdy_rise) begin
              r_state <= VERDICT;
            end
          end
          VERDICT: begin
            r_vld       <= 1'b1;
            r_accept    <= w_accept;
            r_bcast     <= ~r_runt & (r_dst == BCAST_MAC);
            r_runt_o    <= r_runt;
            r_hit_idx_o <= r_hit_idx;
            r_state     <= IDLE;
          end
          LOAD: begin
            if (w_rdy_rise) begin
              r_setup_done <= 1'b1;
              r_state      <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign vld_o        = r_vld;
  assign accept_o     = r_accept;
  assign hit_idx_o    = r_hit_idx_o;
  assign bcast_o      = r_bcast;
  assign runt_o       = r_runt_o;
  assign setup_done_o = r_setup_done;

`ifdef FLT_STATS_EN
  logic [15:0] r_rej_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rej_cnt <= '0;
    end else if (r_state == VERDICT && !w_start && !w_accept && r_rej_cnt != 16'hFFFF) begin
      r_rej_cnt <= r_rej_cnt + 16'd1;
    end
  end

  assign rej_cnt_o = r_rej_cnt;
`endif

endmodule
